// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - SAP-1 control-word bit positions and opcode constants
package sap_pkg;

  // Bit positions inside the 12-bit control word (_N marks active-low bits)
  localparam int unsigned CP   = 11;
  localparam int unsigned EP   = 10;
  localparam int unsigned LM_N = 9;
  localparam int unsigned CE_N = 8;
  localparam int unsigned LI_N = 7;
  localparam int unsigned EI_N = 6;
  localparam int unsigned LA_N = 5;
  localparam int unsigned EA   = 4;
  localparam int unsigned SU   = 3;
  localparam int unsigned EU   = 2;
  localparam int unsigned LB_N = 1;
  localparam int unsigned LO_N = 0;

  // Opcodes carried in IR[7:4]
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

endpackage

// File: rtl/sap_datapath_if.sv
// rtl/sap_datapath_if.sv - control, program-load and status signals of the SAP-1 datapath
interface sap_datapath_if;

  logic [11:0] cu_in;
  logic        prog;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [7:0]  prog_data;
  logic [3:0]  instruction;
  logic [7:0]  out_port;
  logic        halt;
  logic        bus_err;

  // Control unit / loader side
  modport master (
    output cu_in, prog, prog_we, prog_addr, prog_data,
    input  instruction, out_port, halt, bus_err
  );

  // Datapath side
  modport slave (
    input  cu_in, prog, prog_we, prog_addr, prog_data,
    output instruction, out_port, halt, bus_err
  );

endinterface

// File: rtl/sap_ram16x8.sv
// rtl/sap_ram16x8.sv - 16x8 RAM with asynchronous read and synchronous write port
module sap_ram16x8 #(
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic       clk,
  input  logic       we,
  input  logic [3:0] waddr,
  input  logic [7:0] wdata,
  input  logic [3:0] raddr,
  output logic [7:0] rdata
);

  if (INIT_ZERO) begin : g_zero_init
    logic [7:0] mem_q [16] = '{default: 8'h00};

    // Program-port write; contents are never touched by reset
    always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
  end else begin : g_no_init
    logic [7:0] mem_q [16];

    // Program-port write; contents are never touched by reset
    always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
  end

endmodule

// File: rtl/sap_datapath.sv
// rtl/sap_datapath.sv - SAP-1 8-bit datapath: PC, MAR, RAM, IR, A, B, ALU, OUT on a shared W-bus
module sap_datapath
  import sap_pkg::*;
#(
  parameter bit RAM_INIT_ZERO = 1'b1
) (
  input  logic           clk,
  input  logic           clear,
  sap_datapath_if.slave  io
);

  // Decoded control lines, all active-high here
  logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;

  assign cp = io.cu_in[CP];
  assign ep = io.cu_in[EP];
  assign lm = ~io.cu_in[LM_N];
  assign ce = ~io.cu_in[CE_N];
  assign li = ~io.cu_in[LI_N];
  assign ei = ~io.cu_in[EI_N];
  assign la = ~io.cu_in[LA_N];
  assign ea = io.cu_in[EA];
  assign su = io.cu_in[SU];
  assign eu = io.cu_in[EU];
  assign lb = ~io.cu_in[LB_N];
  assign lo = ~io.cu_in[LO_N];

  logic [3:0] pc_q, pc_d, mar_q, mar_d;
  logic [7:0] ir_q, ir_d, a_q, a_d, b_q, b_d, out_q, out_d;
  logic       halt_q, halt_d, bus_err_q, bus_err_d;

  logic [7:0] ram_rdata;
  logic [7:0] alu;
  logic [7:0] w_bus;
  logic [2:0] n_drv;
  logic       load_en;

  sap_ram16x8 #(.INIT_ZERO(RAM_INIT_ZERO)) u_ram (
    .clk   (clk),
    .we    (io.prog & io.prog_we),
    .waddr (io.prog_addr),
    .wdata (io.prog_data),
    .raddr (mar_q),
    .rdata (ram_rdata)
  );

  // Subtraction wraps in two's complement; carry/borrow is dropped
  assign alu = su ? (a_q - b_q) : (a_q + b_q);

  assign n_drv = {2'b00, ep} + {2'b00, ce} + {2'b00, ei} + {2'b00, ea} + {2'b00, eu};

  // Loading is blocked both while the loader owns the machine and once halted
  assign load_en = ~io.prog & ~halt_q;

  // W-bus: fixed-priority driver select, idle bus reads as zero
  always_comb begin
    w_bus = 8'h00;
    if (ep)      w_bus = {4'h0, pc_q};
    else if (ce) w_bus = ram_rdata;
    else if (ei) w_bus = {4'h0, ir_q[3:0]};
    else if (ea) w_bus = a_q;
    else if (eu) w_bus = alu;
  end

  // Next-state: every load samples the pre-edge bus, so read/write of one register per cycle is safe
  always_comb begin
    pc_d      = pc_q;
    mar_d     = mar_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    out_d     = out_q;
    if (load_en) begin
      if (cp) pc_d  = pc_q + 4'd1;
      if (lm) mar_d = w_bus[3:0];
      if (li) ir_d  = w_bus;
      if (la) a_d   = w_bus;
      if (lb) b_d   = w_bus;
      if (lo) out_d = w_bus;
    end
    // Halt follows the latched opcode one edge later and is left only through clear
    halt_d    = halt_q | (ir_q[7:4] == OP_HLT);
    bus_err_d = halt_q ? bus_err_q : (bus_err_q | (n_drv > 3'd1));
  end

  // State registers; clear overrides every load in the same cycle
  always_ff @(posedge clk) begin
    if (clear) begin
      pc_q      <= 4'h0;
      mar_q     <= 4'h0;
      ir_q      <= 8'h00;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      out_q     <= 8'h00;
      halt_q    <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      mar_q     <= mar_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      out_q     <= out_d;
      halt_q    <= halt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign io.instruction = ir_q[7:4];
  assign io.out_port    = out_q;
  assign io.halt        = halt_q;
  assign io.bus_err     = bus_err_q;

endmodule
